// File: rtl/decode_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// decode_stage_pipe_if
//   Handshake bundle between fetch and the decode stage, and between the
//   decode stage and register-read.
//   master : the side that feeds instructions in and takes decoded entries out
//   slave  : the decode stage itself
// Signals
//   in_valid/in_ready/in_insn/in_pc         fetch -> decode transfer
//   out_valid/out_ready                     decode -> register-read transfer
//   out_pc/out_class/out_rd/out_rs/out_rt   decoded entry fields
//   out_shamt/out_aluop/out_imm/out_target
// ---------------------------------------------------------------------------
interface decode_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_insn;
  logic [PC_W-1:0]   in_pc;

  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [10:0]       out_class;
  logic [4:0]        out_rd;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;
  logic [4:0]        out_shamt;
  logic [4:0]        out_aluop;
  logic [DATA_W-1:0] out_imm;
  logic [DATA_W-1:0] out_target;

  modport master (
    output in_valid, in_insn, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_class, out_rd, out_rs, out_rt,
           out_shamt, out_aluop, out_imm, out_target
  );

  modport slave (
    input  in_valid, in_insn, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_class, out_rd, out_rs, out_rt,
           out_shamt, out_aluop, out_imm, out_target
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// ---------------------------------------------------------------------------
// decode_stage_pipe
//   Registered decode stage between fetch and register-read. Instructions
//   are decoded combinationally on entry and stored decoded in a two-entry
//   (main + skid) buffer, so in_ready depends only on registered state.
// Ports
//   clock   rising-edge clock
//   reset   asynchronous, active-high reset
//   flush   synchronous discard of all buffered entries (wins over transfers)
//   bus     decode_stage_pipe_if.slave handshake/data bundle
// Optional feature (macro DECODE_ILLEGAL_TRAP_EN)
//   out_illegal   presented entry carries an unlisted opcode
//   illegal_seen  sticky flag, set when an unlisted opcode is accepted,
//                 cleared only by reset
// ---------------------------------------------------------------------------
module decode_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  decode_stage_pipe_if.slave bus
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic out_illegal,
  output logic illegal_seen
`endif
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [10:0]       cls;
    logic [4:0]        rd;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        shamt;
    logic [4:0]        aluop;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] target;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic              illegal;
`endif
  } entry_t;

  // Occupancy: EMPTY (no entry), ONE (main only), FULL (main + skid).
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t dec;
  entry_t shown;
  logic   accept;
  logic   emit;

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign accept        = bus.in_valid & bus.in_ready;
  assign emit          = bus.out_valid & bus.out_ready;

  // Decode of the incoming instruction; the opcode lives in insn[31:27].
  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    dec        = '0;
    dec.pc     = bus.in_pc;
    dec.rd     = bus.in_insn[26:22];
    dec.rs     = bus.in_insn[21:17];
    dec.rt     = bus.in_insn[16:12];
    dec.shamt  = bus.in_insn[11:7];
    dec.aluop  = bus.in_insn[6:2];
    dec.imm    = DATA_W'($signed(bus.in_insn[16:0]));
    dec.target = DATA_W'(bus.in_insn[26:0]);
    case (bus.in_insn[31:27])
      5'b00000: dec.cls = 11'h001;  // alu
      5'b00001: dec.cls = 11'h002;  // j
      5'b00010: dec.cls = 11'h004;  // bne
      5'b00011: dec.cls = 11'h008;  // jal
      5'b00100: dec.cls = 11'h010;  // jr
      5'b00101: dec.cls = 11'h020;  // addi
      5'b00110: dec.cls = 11'h040;  // blt
      5'b00111: dec.cls = 11'h080;  // sw
      5'b01000: dec.cls = 11'h100;  // lw
      5'b10101: dec.cls = 11'h200;  // setx
      5'b10110: dec.cls = 11'h400;  // bex
      default: begin
        dec.cls = 11'h000;
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec.illegal = 1'b1;
`endif
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the two entry registers are reset as well, so no X can ever reach
  // the outputs even before the first transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_q <= dec;
          state  <= ONE;
        end
        ONE: begin
          if (accept && emit) begin
            main_q <= dec;
          end else if (accept) begin
            skid_q <= dec;
            state  <= FULL;
          end else if (emit) begin
            state <= EMPTY;
          end
        end
        FULL: if (emit) begin
          main_q <= skid_q;
          state  <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Stale main contents are masked so all outputs read 0 while EMPTY.
  assign shown          = (state == EMPTY) ? '0 : main_q;
  assign bus.out_pc     = shown.pc;
  assign bus.out_class  = shown.cls;
  assign bus.out_rd     = shown.rd;
  assign bus.out_rs     = shown.rs;
  assign bus.out_rt     = shown.rt;
  assign bus.out_shamt  = shown.shamt;
  assign bus.out_aluop  = shown.aluop;
  assign bus.out_imm    = shown.imm;
  assign bus.out_target = shown.target;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign out_illegal = shown.illegal;

  // An accept in a flush cycle is dropped, so it does not count as seen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal_seen <= 1'b0;
    end else if (accept && !flush && dec.illegal) begin
      illegal_seen <= 1'b1;
    end
  end
`endif

endmodule
